pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, range 1..65535: max MEM_WAIT cycles before halt.
REQ-002 i_clk  in  1  clock; i_rst_n  in  1  reset, synchronous, active-low.
REQ-003 id_rs1_addr_i, id_rs2_addr_i  in  5 each  ID-stage source registers.
REQ-004 id_rs1_used_i, id_rs2_used_i  in  1 each  ID instruction reads rs1/rs2.
REQ-005 ex_rd_addr_i  in  5  EX-stage destination; ex_ld_i  in  1  EX instruction is a load.
REQ-006 ex_mispred_i  in  1  branch/jump misprediction resolved in EX.
REQ-007 mem_req_i  in  1  MEM-stage data-memory access; mem_ack_i  in  1  data memory completes access.
REQ-008 pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o  out  1 each  stage-register load enables.
REQ-009 if_id_flush_o, id_ex_flush_o  out  1 each  load bubble (zeros) into register.
REQ-010 mem_wb_sel_o  out  1  MEM/WB select: 0 = pass, 1 = bubble.
REQ-011 err_o  out  1  sticky memory-timeout error.

Function
REQ-012 FSM states RUN, MEM_WAIT, HALT; wait counter wait_cnt 16 bits.
REQ-013 RUN defaults: all enables 1, all flushes 0, mem_wb_sel_o 0.
REQ-014 Load-use hazard = ex_ld_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==ex_rd) | (id_rs2_used_i & rs2==ex_rd)).
REQ-015 Priority within RUN: memory wait > mispredict > load-use.
REQ-016 RUN, mem_req_i & !mem_ack_i: pc/if_id/id_ex/ex_mem enables 0, mem_wb_sel_o 1; next MEM_WAIT, wait_cnt<=1.
REQ-017 RUN, mispredict (no wait): if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1; stay RUN.
REQ-018 RUN, load-use only: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; stay RUN; clears itself next cycle.
REQ-019 MEM_WAIT, !mem_ack_i: outputs as REQ-016; wait_cnt increments; when wait_cnt==MEM_TIMEOUT next HALT, err_o<=1.
REQ-020 MEM_WAIT, mem_ack_i: outputs per RUN rules REQ-013/017/018 (memory wait term ignored); next RUN, wait_cnt<=0.
REQ-021 Mispredict or load-use arriving during MEM_WAIT held by frozen EX; acted on in ack cycle.
REQ-022 HALT: all enables 0, flushes 0, mem_wb_sel_o 1, err_o 1; exit only by reset.
REQ-023 mem_req_i & mem_ack_i same cycle in RUN: no stall (zero-wait access).
REQ-024 All outputs combinational from state plus inputs; no other latency.

Reset
REQ-025 While i_rst_n=0: state<=RUN, wait_cnt<=0, err_o<=0; outputs: enables 1, flushes 1, mem_wb_sel_o 1.
REQ-026 Reset mid-MEM_WAIT or HALT returns RUN next cycle; pending access abandoned.

Configuration
REQ-027 Macro PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt_o, flush_cnt_o (32 bits, reset 0, wrap at 2^32-1 to 0).
REQ-028 stall_cnt_o increments every cycle pc_en_o=0; flush_cnt_o increments every cycle id_ex_flush_o=1 outside reset.
REQ-029 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-030 Package pipe_pkg holds state enum typedef, REG_ADDR_W=5, WAIT_CNT_W=16.
REQ-031 Sub-module hazard_detect computes load-use hazard (REQ-014) combinationally; FSM stays in pipe_ctrl.

Verification
REQ-032 ex_ld_i=1, ex_rd=5, id_rs1=5 used -> one cycle pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; then defaults.
REQ-033 ex_ld_i=1, ex_rd=0, id_rs1=0 used -> no stall.
REQ-034 mem_req_i=1, ack after 3 cycles -> enables 0 and mem_wb_sel_o 1 for 3 cycles, release on ack cycle.
REQ-035 MEM_TIMEOUT=4, ack never -> HALT, err_o=1 after cycle 4; reset clears, RUN resumes.
REQ-036 ex_mispred_i with load-use same cycle -> both flushes 1, pc_en_o 1.
REQ-037 PIPE_CTRL_PERF_EN: scenario REQ-034 -> stall_cnt_o=3; undefined build elaborates without ports.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WAIT_CNT_W = 16;
    localparam int unsigned PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_sel;
    } pipe_ctl_t;

    // Flowing pipeline, optionally redirected by a mispredict or held for a load-use bubble.
    function automatic pipe_ctl_t run_ctl(input logic mispred, input logic load_use);
        pipe_ctl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
              if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_sel: 1'b0};
        if (mispred) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
            c.pc_en       = 1'b1;
        end else if (load_use) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

    // Everything up to EX/MEM frozen, bubble fed into WB.
    function automatic pipe_ctl_t freeze_ctl();
        pipe_ctl_t c;
        c = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
              if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_sel: 1'b1};
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: EX holds a load whose destination an ID source operand needs.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_ld,
    output logic                  load_use_c
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real dependency.
    assign rd_nonzero = (ex_rd_addr != '0);
    assign rs1_hit    = rs1_used && (rs1_addr == ex_rd_addr);
    assign rs2_hit    = rs2_used && (rs2_addr == ex_rd_addr);
    assign load_use_c = ex_ld && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush controller with data-memory timeout.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_ld_i,
    input  logic                  ex_mispred_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  id_ex_en_o,
    output logic                  ex_mem_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  mem_wb_sel_o,
    output logic                  err_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o
`endif
);

    pipe_state_e           state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  err_q;
    logic                  load_use;
    logic                  mem_stall;
    pipe_ctl_t             ctl;

    hazard_detect u_hazard_detect (
        .rs1_addr   (id_rs1_addr_i),
        .rs2_addr   (id_rs2_addr_i),
        .rs1_used   (id_rs1_used_i),
        .rs2_used   (id_rs2_used_i),
        .ex_rd_addr (ex_rd_addr_i),
        .ex_ld      (ex_ld_i),
        .load_use_c (load_use)
    );

    // A same-cycle ack is a zero-wait access and never stalls.
    assign mem_stall = mem_req_i && !mem_ack_i;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                        if (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT)) begin
                            state <= ST_HALT;
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Stage controls follow state and inputs with no added latency.
    always_comb begin
        ctl = run_ctl(1'b0, 1'b0);
        if (!i_rst_n) begin
            ctl = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                    if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_sel: 1'b1};
        end else begin
            case (state)
                ST_RUN:      ctl = mem_stall ? freeze_ctl() : run_ctl(ex_mispred_i, load_use);
                ST_MEM_WAIT: ctl = mem_ack_i ? run_ctl(ex_mispred_i, load_use) : freeze_ctl();
                ST_HALT:     ctl = freeze_ctl();
                default:     ctl = run_ctl(1'b0, 1'b0);
            endcase
        end
    end

    assign pc_en_o       = ctl.pc_en;
    assign if_id_en_o    = ctl.if_id_en;
    assign id_ex_en_o    = ctl.id_ex_en;
    assign ex_mem_en_o   = ctl.ex_mem_en;
    assign if_id_flush_o = ctl.if_id_flush;
    assign id_ex_flush_o = ctl.id_ex_flush;
    assign mem_wb_sel_o  = ctl.mem_wb_sel;
    assign err_o         = err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt;
    logic [PERF_CNT_W-1:0] flush_cnt;

    // Free-running event counters; natural wrap at 2^32.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctl.pc_en) begin
                stall_cnt <= stall_cnt + PERF_CNT_W'(1);
            end
            if (ctl.id_ex_flush) begin
                flush_cnt <= flush_cnt + PERF_CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`endif

endmodule
